// File: rtl/router_rr.sv
// router_rr: N-port NoC router with per-input FIFOs, table-driven routing and a
// round-robin crossbar. Define ROUTER_STATS_EN to add saturating forward/drop counters.
module router_rr #(
  parameter int id     = -1,
  parameter int PORTS  = 5,
  parameter int SIZE   = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 4,
  parameter int DIR_W  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PORTS-1:0]        rx_req,
  output logic [PORTS-1:0]        rx_ack,
  input  logic [PORTS*SIZE-1:0]   rx_data,
  output logic [PORTS-1:0]        tx_req,
  input  logic [PORTS-1:0]        tx_ack,
  output logic [PORTS*SIZE-1:0]   tx_data,
  output logic [PORTS*ADDR_W-1:0] table_addr,
  input  logic [PORTS*DIR_W-1:0]  table_data
`ifdef ROUTER_STATS_EN
  ,
  output logic [PORTS*16-1:0]     fwd_count,
  output logic [15:0]             drop_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [SIZE-1:0]  mem_r       [PORTS][DEPTH];
  logic [AW-1:0]    wr_ptr_r    [PORTS];
  logic [AW-1:0]    rd_ptr_r    [PORTS];
  logic [AW:0]      cnt_r       [PORTS];
  logic [AW:0]      cnt_next_s  [PORTS];
  logic [SIZE-1:0]  tx_data_r   [PORTS];
  logic [PW-1:0]    rr_r        [PORTS];
  logic [PW-1:0]    rr_next_s   [PORTS];
  logic [PW-1:0]    grant_idx_s [PORTS];
  logic [SIZE-1:0]  head_s      [PORTS];
  logic [DIR_W-1:0] dir_s       [PORTS];
  logic [PORTS-1:0] rx_ack_r, tx_req_r;
  logic [PORTS-1:0] empty_s, push_s, pop_s, drop_s, grant_v_s;
  logic [PW-1:0]    idx_s;

  function automatic logic [PW-1:0] mod_add(input logic [PW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= PORTS) begin
      sum = sum - PORTS;
    end else begin
      sum = sum;
    end
    return PW'(sum);
  endfunction

  // Per-input head presentation, table lookup and bad-direction drop decode.
  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      empty_s[i] = (cnt_r[i] == '0);
      head_s[i]  = mem_r[i][rd_ptr_r[i]];
      dir_s[i]   = table_data[i*DIR_W +: DIR_W];
      push_s[i]  = rx_req[i] & rx_ack_r[i];
      drop_s[i]  = !empty_s[i] && (int'(dir_s[i]) >= PORTS);
      table_addr[i*ADDR_W +: ADDR_W] = head_s[i][ADDR_W-1:0];
    end
  end

  // Round-robin search per output; each head matches only its own direction,
  // so an input can win at most one output per cycle.
  always_comb begin
    pop_s = drop_s;
    idx_s = '0;
    for (int o = 0; o < PORTS; o++) begin
      grant_v_s[o]   = 1'b0;
      grant_idx_s[o] = rr_r[o];
      if (!tx_req_r[o] || tx_ack[o]) begin
        for (int k = 0; k < PORTS; k++) begin
          idx_s = mod_add(rr_r[o], k);
          if (!grant_v_s[o] && !empty_s[idx_s] && (int'(dir_s[idx_s]) == o)) begin
            grant_v_s[o]   = 1'b1;
            grant_idx_s[o] = idx_s;
            pop_s[idx_s]   = 1'b1;
          end else begin
            grant_v_s[o] = grant_v_s[o];
          end
        end
      end else begin
        grant_v_s[o] = 1'b0;
      end
      rr_next_s[o] = mod_add(grant_idx_s[o], 1);
    end
  end

  // Occupancy update: simultaneous push and pop leave the count unchanged.
  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      case ({push_s[i], pop_s[i]})
        2'b10:   cnt_next_s[i] = cnt_r[i] + CNT_ONE;
        2'b01:   cnt_next_s[i] = cnt_r[i] - CNT_ONE;
        default: cnt_next_s[i] = cnt_r[i];
      endcase
    end
  end

  // FIFO storage is not reset; the occupancy counters decide what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < PORTS; i++) begin
      if (reset && push_s[i]) begin
        mem_r[i][wr_ptr_r[i]] <= rx_data[i*SIZE +: SIZE];
      end
    end
  end

  // FIFO pointers, registered accept, output registers and round-robin pointers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_ack_r <= '0;
      tx_req_r <= '0;
      for (int i = 0; i < PORTS; i++) begin
        wr_ptr_r[i]  <= '0;
        rd_ptr_r[i]  <= '0;
        cnt_r[i]     <= '0;
        tx_data_r[i] <= '0;
        rr_r[i]      <= '0;
      end
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        if (push_s[i]) wr_ptr_r[i] <= wr_ptr_r[i] + PTR_ONE;
        if (pop_s[i])  rd_ptr_r[i] <= rd_ptr_r[i] + PTR_ONE;
        cnt_r[i]    <= cnt_next_s[i];
        rx_ack_r[i] <= (cnt_next_s[i] != CNT_FULL);
      end
      for (int o = 0; o < PORTS; o++) begin
        if (grant_v_s[o]) begin
          tx_data_r[o] <= head_s[grant_idx_s[o]];
          tx_req_r[o]  <= 1'b1;
          rr_r[o]      <= rr_next_s[o];
        end else if (tx_ack[o]) begin
          tx_req_r[o]  <= 1'b0;
        end
      end
    end
  end

  assign rx_ack = rx_ack_r;
  assign tx_req = tx_req_r;

  // Flatten the output data registers onto the bus.
  always_comb begin
    for (int o = 0; o < PORTS; o++) begin
      tx_data[o*SIZE +: SIZE] = tx_data_r[o];
    end
  end

`ifdef ROUTER_STATS_EN
  logic [15:0] fwd_cnt_r [PORTS];
  logic [15:0] drop_cnt_r;
  logic [15:0] drop_inc_s;
  logic [16:0] drop_sum_s;

  // Number of heads dropped this cycle and the unsaturated new total.
  always_comb begin
    drop_inc_s = 16'd0;
    for (int i = 0; i < PORTS; i++) begin
      drop_inc_s = drop_inc_s + {15'd0, drop_s[i]};
    end
    drop_sum_s = {1'b0, drop_cnt_r} + {1'b0, drop_inc_s};
  end

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_cnt_r <= 16'd0;
      for (int o = 0; o < PORTS; o++) fwd_cnt_r[o] <= 16'd0;
    end else begin
      drop_cnt_r <= drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
      for (int o = 0; o < PORTS; o++) begin
        if (grant_v_s[o] && (fwd_cnt_r[o] != 16'hFFFF)) fwd_cnt_r[o] <= fwd_cnt_r[o] + 16'd1;
      end
    end
  end

  // Flatten the per-output forward counters.
  always_comb begin
    for (int o = 0; o < PORTS; o++) begin
      fwd_count[o*16 +: 16] = fwd_cnt_r[o];
    end
  end
  assign drop_count = drop_cnt_r;
`endif
endmodule
